// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the intersection sequencer: phase encoding, light
// one-hot constants, default phase durations and per-road light decoding.
// The phase code is also the value of the traffic_sequencer `phase` port.
// ---------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [2:0] {
        INIT = 3'd0,
        NS_G = 3'd1,
        NS_Y = 3'd2,
        RED1 = 3'd3,
        EW_G = 3'd4,
        EW_Y = 3'd5,
        RED2 = 3'd6,
        WALK = 3'd7
    } phase_t;

    // Light one-hots, bit order {red, yellow, green}.
    localparam logic [2:0] LT_RED = 3'b100;
    localparam logic [2:0] LT_YEL = 3'b010;
    localparam logic [2:0] LT_GRN = 3'b001;

    // Default durations. A phase with value D lasts D+1 ticks.
    localparam int unsigned DEF_TICK_CYCLES = 50_000_000;
    localparam int unsigned DEF_NS_GREEN    = 9;
    localparam int unsigned DEF_NS_YELLOW   = 3;
    localparam int unsigned DEF_EW_GREEN    = 6;
    localparam int unsigned DEF_EW_YELLOW   = 3;
    localparam int unsigned DEF_ALL_RED     = 1;
    localparam int unsigned DEF_PED_WALK    = 5;

    function automatic logic [2:0] ns_lights(input phase_t p);
        case (p)
            NS_G:    return LT_GRN;
            NS_Y:    return LT_YEL;
            default: return LT_RED;
        endcase
    endfunction

    function automatic logic [2:0] ew_lights(input phase_t p);
        case (p)
            EW_G:    return LT_GRN;
            EW_Y:    return LT_YEL;
            default: return LT_RED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_sequencer_sec_tick_gen.sv
// ---------------------------------------------------------------------------
// sec_tick_gen
// Prescaler producing a registered one-clk `tick` every TICK_CYCLES enabled
// clocks. `tick` is high during the cycle in which the count equals
// TICK_CYCLES-1; the count wraps on the following edge.
// Ports:
//   clk  - system clock
//   rst  - asynchronous reset, active-low
//   en   - run enable; low holds the count and clears tick
//   tick - one-clk pulse per elapsed tick
// ---------------------------------------------------------------------------
module sec_tick_gen #(
    parameter int unsigned TICK_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // If en drops during a tick cycle, the tick is withdrawn and the count
    // parks at LAST; the first enabled edge afterwards re-raises tick without
    // moving the count, so a pause never swallows a tick.
    always_comb begin
        if (tick)
            cnt_nxt = '0;
        else if (cnt == LAST)
            cnt_nxt = cnt;
        else
            cnt_nxt = cnt + 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en) begin
            cnt  <= cnt_nxt;
            tick <= (cnt_nxt == LAST);
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/traffic_sequencer.sv
// ---------------------------------------------------------------------------
// traffic_sequencer
// Two-road intersection sequencer. Walks NS_G -> NS_Y -> RED1 -> EW_G ->
// EW_Y -> RED2 -> (WALK) -> NS_G, one step per expired phase, counting the
// phase down in ticks from sec_tick_gen. All outputs are registered.
// Build option: define TRAFFIC_PED_REQ_EN to enable the pedestrian phase;
// otherwise ped_req is ignored and ped_walk / ped_pending stay 0.
// Ports:
//   clk, rst     - clock; asynchronous active-low reset
//   en           - run enable (freezes prescaler and FSM when low)
//   ped_req      - pedestrian button level
//   tick         - one-clk pulse per tick
//   phase        - current phase code (traffic_pkg::phase_t)
//   sec_left     - ticks remaining in the phase
//   ns_light     - NS one-hot {red, yellow, green}
//   ew_light     - EW one-hot {red, yellow, green}
//   ped_walk     - walk lamp
//   ped_pending  - latched, not-yet-served pedestrian request
// ---------------------------------------------------------------------------
module traffic_sequencer
    import traffic_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = DEF_TICK_CYCLES,
    parameter int unsigned NS_GREEN    = DEF_NS_GREEN,
    parameter int unsigned NS_YELLOW   = DEF_NS_YELLOW,
    parameter int unsigned EW_GREEN    = DEF_EW_GREEN,
    parameter int unsigned EW_YELLOW   = DEF_EW_YELLOW,
    parameter int unsigned ALL_RED     = DEF_ALL_RED,
    parameter int unsigned PED_WALK    = DEF_PED_WALK
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       ped_req,
    output logic       tick,
    output logic [2:0] phase,
    output logic [3:0] sec_left,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       ped_walk,
    output logic       ped_pending
);

    phase_t state;
    phase_t state_nxt;
    logic   step;
    logic   walk_go;

    sec_tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .tick(tick)
    );

    // A tick only counts while enabled; tick can still be high in the first
    // cycle after en falls.
    assign step  = tick && en;
    assign phase = state;

    function automatic logic [3:0] dur_of(input phase_t p);
        case (p)
            NS_G:       return 4'(NS_GREEN);
            NS_Y:       return 4'(NS_YELLOW);
            RED1, RED2: return 4'(ALL_RED);
            EW_G:       return 4'(EW_GREEN);
            EW_Y:       return 4'(EW_YELLOW);
            WALK:       return 4'(PED_WALK);
            default:    return 4'd0;
        endcase
    endfunction

`ifdef TRAFFIC_PED_REQ_EN
    // The live button is OR-ed in so a press during the RED2 exit tick is served.
    assign walk_go = ped_pending || ped_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ped_pending <= 1'b0;
        else if (step && state == RED2 && sec_left == 4'd0 && walk_go)
            ped_pending <= 1'b0;
        else if (ped_req && state != WALK)
            ped_pending <= 1'b1;
    end
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
    assign walk_go        = 1'b0;
    assign ped_pending    = 1'b0;
`endif

    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    state_nxt = NS_G;
            NS_G:    state_nxt = NS_Y;
            NS_Y:    state_nxt = RED1;
            RED1:    state_nxt = EW_G;
            EW_G:    state_nxt = EW_Y;
            EW_Y:    state_nxt = RED2;
            RED2:    state_nxt = walk_go ? WALK : NS_G;
            WALK:    state_nxt = NS_G;
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= INIT;
            sec_left <= 4'd0;
            ns_light <= LT_RED;
            ew_light <= LT_RED;
            ped_walk <= 1'b0;
        end else if (step) begin
            if (sec_left != 4'd0) begin
                sec_left <= sec_left - 4'd1;
            end else begin
                state    <= state_nxt;
                sec_left <= dur_of(state_nxt);
                ns_light <= ns_lights(state_nxt);
                ew_light <= ew_lights(state_nxt);
                ped_walk <= (state_nxt == WALK);
            end
        end
    end

endmodule

// File: tb/tb_traffic_sequencer.sv
// ---------------------------------------------------------------------------
// tb_traffic_sequencer
// Scoreboard bench for traffic_sequencer with TICK_CYCLES=4 and default
// durations. A reference model advances on each rising edge from the input
// values and pushes the expected outputs for the next cycle; a monitor pops
// and compares on every falling edge.
// ---------------------------------------------------------------------------
module tb_traffic_sequencer;

    localparam int TB_TICK = 4;

    logic       clk;
    logic       rst;
    logic       en;
    logic       ped_req;
    logic       tick;
    logic [2:0] phase;
    logic [3:0] sec_left;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       ped_walk;
    logic       ped_pending;

    traffic_sequencer #(
        .TICK_CYCLES(TB_TICK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .ped_req    (ped_req),
        .tick       (tick),
        .phase      (phase),
        .sec_left   (sec_left),
        .ns_light   (ns_light),
        .ew_light   (ew_light),
        .ped_walk   (ped_walk),
        .ped_pending(ped_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s wait budget expired at %0t", name, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int tick;
        int phase;
        int sec;
        int ns;
        int ew;
        int walk;
        int pend;
    } exp_t;

    exp_t sb_q[$];

    // Durations indexed by phase code: INIT, NS_G, NS_Y, RED1, EW_G, EW_Y, RED2, WALK.
    int dur[8] = '{0, 9, 3, 1, 6, 3, 1, 5};

    int m_phase = 0;
    int m_sec   = 0;
    int m_pend  = 0;
    int m_cnt   = 0;   // enabled edges since reset, modulo TB_TICK
    int m_tick  = 0;   // tick expected in the current cycle
    int seen_walk = 0;

    function automatic int ns_of(input int p);
        return (p == 1) ? 32'h1 : (p == 2) ? 32'h2 : 32'h4;
    endfunction

    function automatic int ew_of(input int p);
        return (p == 4) ? 32'h1 : (p == 5) ? 32'h2 : 32'h4;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        int   eff;
        int   go_walk;
        if (!rst) begin
            m_phase = 0;
            m_sec   = 0;
            m_pend  = 0;
            m_cnt   = 0;
            m_tick  = 0;
        end else begin
            eff = (m_tick != 0 && en) ? 1 : 0;
`ifdef TRAFFIC_PED_REQ_EN
            go_walk = (m_pend != 0 || ped_req) ? 1 : 0;
            if (eff != 0 && m_phase == 6 && m_sec == 0 && go_walk != 0)
                m_pend = 0;
            else if (ped_req && m_phase != 7)
                m_pend = 1;
`else
            go_walk = 0;
`endif
            if (eff != 0) begin
                if (m_sec > 0) begin
                    m_sec = m_sec - 1;
                end else begin
                    if (m_phase == 6)
                        m_phase = (go_walk != 0) ? 7 : 1;
                    else if (m_phase == 7)
                        m_phase = 1;
                    else
                        m_phase = m_phase + 1;
                    m_sec = dur[m_phase];
                end
            end
            if (en)
                m_cnt = (m_cnt + 1) % TB_TICK;
            m_tick = (en && m_cnt == TB_TICK - 1) ? 1 : 0;
        end
        e.tick  = m_tick;
        e.phase = m_phase;
        e.sec   = m_sec;
        e.ns    = ns_of(m_phase);
        e.ew    = ew_of(m_phase);
        e.walk  = (m_phase == 7) ? 1 : 0;
        e.pend  = m_pend;
        sb_q.push_back(e);
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() == 0) begin
            note_fail("scoreboard_empty");
        end else begin
            e = sb_q.pop_front();
            if (!rst) begin
                // Asynchronous reset overrides whatever was predicted.
                e.tick = 0; e.phase = 0; e.sec = 0; e.ns = 4; e.ew = 4; e.walk = 0; e.pend = 0;
            end
            check("tick",        32'(tick),        e.tick);
            check("phase",       32'(phase),       e.phase);
            check("sec_left",    32'(sec_left),    e.sec);
            check("ns_light",    32'(ns_light),    e.ns);
            check("ew_light",    32'(ew_light),    e.ew);
            check("ped_walk",    32'(ped_walk),    e.walk);
            check("ped_pending", 32'(ped_pending), e.pend);
            if (phase == 3'd7)
                seen_walk++;
        end
    end

    // ---------------- stimulus ----------------
    function automatic bit cond_met(input int which);
        case (which)
            1: return m_phase == 4;
            2: return m_phase == 6 && m_sec == 0 && m_tick != 0;
            3: return m_phase == 1 && m_sec == 5 && m_cnt == 0;
            4: return m_phase == 5;
            5: return m_phase == 1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_cond(input int which, input string name);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (cond_met(which))
                return;
        end
        note_fail(name);
    endtask

    task automatic run_random(input int cycles, input int ped_div, input bit rand_en);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            ped_req = ($urandom % ped_div) == 0;
            // Pauses never start on a tick cycle so the model's tick rule holds.
            if (rand_en && m_tick == 0)
                en = ($urandom % 8) != 0;
            else
                en = 1'b1;
        end
        @(negedge clk);
        ped_req = 1'b0;
        en      = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1);
    end

    initial begin
        rst     = 1'b0;
        en      = 1'b1;
        ped_req = 1'b0;
        #12;
        check("reset_phase",    32'(phase),    32'd0);
        check("reset_sec_left", 32'(sec_left), 32'd0);
        check("reset_ns_light", 32'(ns_light), 32'h4);
        check("reset_ew_light", 32'(ew_light), 32'h4);
        check("reset_tick",     32'(tick),     32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Full cycle without requests.
        repeat (140) @(negedge clk);

        // Single-clk request during EW_G.
        wait_cond(1, "wait_ew_g");
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        wait_cond(5, "wait_ns_g_after_req");

        // Request only in the RED2 exit-tick cycle.
        wait_cond(2, "wait_red2_exit_a");
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;

        // Request in the exit tick, then held through WALK only.
        wait_cond(2, "wait_red2_exit_b");
        ped_req = 1'b1;
        do @(negedge clk); while (m_phase == 7);
        ped_req = 1'b0;

        // Freeze mid NS_G at sec_left 5 right after a tick.
        wait_cond(3, "wait_ns_g_5");
        en = 1'b0;
        repeat (10) @(negedge clk);
        en = 1'b1;
        repeat (200) @(negedge clk);

        // Random traffic with requests and enable drops.
        run_random(800, 50, 1'b1);

        // Reset mid EW_Y, checked before the next clock edge.
        wait_cond(4, "wait_ew_y");
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_phase",    32'(phase),    32'd0);
        check("rst_mid_ns_light", 32'(ns_light), 32'h4);
        check("rst_mid_ew_light", 32'(ew_light), 32'h4);
        check("rst_mid_sec_left", 32'(sec_left), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_random(400, 20, 1'b1);

`ifndef TRAFFIC_PED_REQ_EN
        check("walk_unreachable", 32'(seen_walk), 32'd0);
`endif
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
